// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Converts a DATA_W-bit result (unsigned or two's complement) to NUM_DIGITS
// seven-segment decimal digits using a bit-serial double-dabble. Provides a
// static per-digit segment bus with leading-zero blanking, a sign flag, an
// overflow flag (all digits show a dash) and a one-hot multiplexed scan port.
module seg_display_ctrl #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         load,
  input  logic [DATA_W-1:0]            value,
  input  logic                         signed_mode,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_DIGITS-1:0][6:0]   display,
  output logic                         neg,
  output logic                         ovf,
  output logic [6:0]                   scan_seg,
  output logic [NUM_DIGITS-1:0]        scan_an
);

  // Internal BCD is sized for the full DATA_W range so overflow can be seen
  // even when fewer digits are driven.
  localparam int BCD_D  = (DATA_W + 2) / 3;
  localparam int BCD_W  = 4 * BCD_D;
  localparam int PAD_D  = (NUM_DIGITS > BCD_D) ? NUM_DIGITS : BCD_D;
  localparam int PAD_W  = 4 * PAD_D;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // Segment pattern {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t                       r_state;
  logic   [DATA_W-1:0]          r_mag;
  logic   [BCD_W-1:0]           r_bcd;
  logic                         r_sgn;
  logic   [CNT_W-1:0]           r_cnt;
  logic   [SCAN_W-1:0]          r_scan_cnt;

  logic                         w_sgn_in;
  logic   [DATA_W-1:0]          w_mag_in;
  logic   [BCD_W-1:0]           w_bcd_adj;
  logic   [PAD_W-1:0]           w_bcd_pad;
  logic   [NUM_DIGITS-1:0][6:0] w_disp;
  logic                         w_ovf;
  logic                         w_lead;
  logic   [3:0]                 w_dig;
  logic   [NUM_DIGITS-1:0]      w_an_rot;

  // Sign/magnitude of the incoming value; the most negative value maps to
  // magnitude 2^(DATA_W-1), which still fits in DATA_W unsigned bits.
  always_comb begin
    w_sgn_in = signed_mode & value[DATA_W-1];
    w_mag_in = w_sgn_in ? ((~value) + DATA_W'(1)) : value;
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Decode finished BCD into blanked segments and the overflow flag.
  always_comb begin
    w_bcd_pad = PAD_W'(r_bcd);
    w_ovf     = 1'b0;
    w_disp    = '0;
    w_lead    = 1'b1;
    w_dig     = 4'd0;
    for (int i = NUM_DIGITS; i < PAD_D; i++) begin
      if (w_bcd_pad[4*i +: 4] != 4'd0) begin
        w_ovf = 1'b1;
      end
    end
    // Walk from the most significant digit down; zeros stay blank until the
    // first nonzero digit, and digit 0 is always shown.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_dig = w_bcd_pad[4*i +: 4];
      if ((w_dig != 4'd0) || (i == 0)) begin
        w_lead = 1'b0;
      end
      if (w_ovf) begin
        w_disp[i] = SEG_DASH;
      end else if (w_lead) begin
        w_disp[i] = SEG_BLANK;
      end else begin
        w_disp[i] = seg_encode(w_dig);
      end
    end
  end

  // Conversion FSM: latch on load, DATA_W shift cycles, then one update cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      display <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_mag   <= w_mag_in;
            r_sgn   <= w_sgn_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
          r_mag <= {r_mag[DATA_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          display <= w_disp;
          neg     <= r_sgn;
          ovf     <= w_ovf;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One-hot enable rotated left by one position, top digit wrapping to 0.
  always_comb begin
    w_an_rot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_rot[(i + 1) % NUM_DIGITS] = scan_an[i];
    end
  end

  // Free-running scan timer; advances the digit enable on every wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_scan_cnt <= '0;
      scan_an    <= NUM_DIGITS'(1);
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      scan_an    <= w_an_rot;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Segments of whichever digit is currently enabled.
  always_comb begin
    scan_seg = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_an[i]) begin
        scan_seg = display[i];
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: two instances (3 digits / scan 4, and
// 2 digits / scan 3) checked every cycle against a decimal-arithmetic model,
// plus directed cases with hand-computed segment patterns.
module tb_seg_display_ctrl;

  localparam int DW  = 8;
  localparam int LAT = DW + 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic            loadA, smA, busyA, doneA, negA, ovfA;
  logic [7:0]      valA;
  logic [2:0][6:0] dispA;
  logic [6:0]      segA;
  logic [2:0]      anA;

  logic            loadB, smB, busyB, doneB, negB, ovfB;
  logic [7:0]      valB;
  logic [1:0][6:0] dispB;
  logic [6:0]      segB;
  logic [1:0]      anB;

  seg_display_ctrl #(.DATA_W(DW), .NUM_DIGITS(3), .SCAN_DIV(4)) dut_a (
    .CLK(CLK), .RST(RST), .load(loadA), .value(valA), .signed_mode(smA),
    .busy(busyA), .done(doneA), .display(dispA), .neg(negA), .ovf(ovfA),
    .scan_seg(segA), .scan_an(anA)
  );

  seg_display_ctrl #(.DATA_W(DW), .NUM_DIGITS(2), .SCAN_DIV(3)) dut_b (
    .CLK(CLK), .RST(RST), .load(loadB), .value(valB), .signed_mode(smB),
    .busy(busyB), .done(doneB), .display(dispB), .neg(negB), .ovf(ovfB),
    .scan_seg(segB), .scan_an(anB)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state per instance.
  logic [6:0] m_disp [2][3];
  logic       m_neg  [2];
  logic       m_ovf  [2];
  logic       m_busy [2];
  logic       m_done [2];
  int         m_cnt  [2];
  int         m_scnt [2];
  int         m_sidx [2];
  logic [6:0] p_disp [2][3];
  logic       p_neg  [2];
  logic       p_ovf  [2];

  task automatic check(input string name, input int id,
                       input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, id, got, exp, $time);
    end
  endtask

  // Expected result of converting v: decimal digits by division.
  task automatic model_result(input int id, input logic [7:0] v, input bit sm, input int nd);
    int  mag, lim, pw;
    bit  s;
    s   = sm && v[7];
    mag = s ? (256 - int'(v)) : int'(v);
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    p_neg[id] = s;
    p_ovf[id] = (mag >= lim);
    pw = 1;
    for (int i = 0; i < 3; i++) begin
      if (i >= nd)              p_disp[id][i] = 7'h00;
      else if (mag >= lim)      p_disp[id][i] = 7'h40;
      else if (i > 0 && mag < pw) p_disp[id][i] = 7'h00;
      else                      p_disp[id][i] = seg_tab[(mag / pw) % 10];
      pw = pw * 10;
    end
  endtask

  task automatic model_step(input int id, input bit rst, input bit ld, input logic [7:0] v,
                            input bit sm, input int nd, input int sd);
    if (rst) begin
      m_busy[id] = 1'b0; m_done[id] = 1'b0; m_cnt[id] = 0;
      m_neg[id]  = 1'b0; m_ovf[id]  = 1'b0;
      for (int i = 0; i < 3; i++) m_disp[id][i] = 7'h00;
      m_scnt[id] = 0; m_sidx[id] = 0;
    end else begin
      m_done[id] = 1'b0;
      if (m_busy[id]) begin
        m_cnt[id]--;
        if (m_cnt[id] == 0) begin
          for (int i = 0; i < 3; i++) m_disp[id][i] = p_disp[id][i];
          m_neg[id]  = p_neg[id];
          m_ovf[id]  = p_ovf[id];
          m_done[id] = 1'b1;
          m_busy[id] = 1'b0;
        end
      end else if (ld) begin
        model_result(id, v, sm, nd);
        m_busy[id] = 1'b1;
        m_cnt[id]  = LAT;
      end
      if (m_scnt[id] == sd - 1) begin
        m_scnt[id] = 0;
        m_sidx[id] = (m_sidx[id] + 1) % nd;
      end else begin
        m_scnt[id]++;
      end
    end
  endtask

  always @(posedge CLK) begin
    model_step(0, RST, loadA, valA, smA, 3, 4);
    model_step(1, RST, loadB, valB, smB, 2, 3);
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", 0, busyA, m_busy[0]);
      check("done", 0, doneA, m_done[0]);
      check("neg",  0, negA,  m_neg[0]);
      check("ovf",  0, ovfA,  m_ovf[0]);
      for (int i = 0; i < 3; i++) check("disp", 0, dispA[i], m_disp[0][i]);
      check("scan_an",  0, anA,  3'b001 << m_sidx[0]);
      check("scan_seg", 0, segA, m_disp[0][m_sidx[0]]);
      check("busy", 1, busyB, m_busy[1]);
      check("done", 1, doneB, m_done[1]);
      check("neg",  1, negB,  m_neg[1]);
      check("ovf",  1, ovfB,  m_ovf[1]);
      for (int i = 0; i < 2; i++) check("disp", 1, dispB[i], m_disp[1][i]);
      check("scan_an",  1, anB,  2'b01 << m_sidx[1]);
      check("scan_seg", 1, segB, m_disp[1][m_sidx[1]]);
    end
  end

  // Issue one load on instance id and wait for done; returns cycles from
  // the sampling edge's following negedge to the first done.
  task automatic do_load(input int id, input logic [7:0] v, input bit sm, output int lat);
    if (id == 0) begin loadA = 1'b1; valA = v; smA = sm; end
    else         begin loadB = 1'b1; valB = v; smB = sm; end
    @(negedge CLK);
    loadA = 1'b0; loadB = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if ((id == 0 && doneA) || (id == 1 && doneB)) begin
        lat = i;
        break;
      end
    end
    check("latency", id, lat, LAT);
  endtask

  initial begin
    int lat, ndone, first;
    logic [2:0] prev_an;
    bit found;
    logic [2:0] exp_an [3];
    logic [6:0] exp_seg [3];
    logic [7:0] specials [8];

    RST = 1'b1;
    loadA = 1'b0; valA = '0; smA = 1'b0;
    loadB = 1'b0; valB = '0; smB = 1'b0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    check("rst_disp", 0, dispA, 0);
    check("rst_an",   0, anA, 3'b001);
    check("rst_busy", 0, busyA, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Zero shows a single '0'.
    do_load(0, 8'd0, 1'b0, lat);
    check("lit_0", 0, dispA, {7'h00, 7'h00, 7'h3F});
    check("lit_0_neg", 0, negA, 0);
    @(negedge CLK);
    check("done_1cyc", 0, doneA, 0);

    do_load(0, 8'd255, 1'b0, lat);
    check("lit_255", 0, dispA, {7'h5B, 7'h6D, 7'h6D});

    // Scan sequence with 255 on display: 6D, 6D, 5B for digits 0,1,2.
    found = 1'b0;
    prev_an = anA;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (prev_an == 3'b001 && anA == 3'b010) begin found = 1'b1; break; end
      prev_an = anA;
    end
    check("scan_sync", 0, found, 1);
    exp_an  = '{3'b010, 3'b100, 3'b001};
    exp_seg = '{7'h6D, 7'h5B, 7'h6D};
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(j == 0 && k == 0)) @(negedge CLK);
        check("lit_scan_an",  0, anA,  exp_an[j]);
        check("lit_scan_seg", 0, segA, exp_seg[j]);
      end
    end

    do_load(0, 8'd7, 1'b0, lat);
    check("lit_7", 0, dispA, {7'h00, 7'h00, 7'h07});
    do_load(0, 8'h80, 1'b1, lat);
    check("lit_m128", 0, dispA, {7'h06, 7'h5B, 7'h7F});
    check("lit_m128_neg", 0, negA, 1);
    do_load(0, 8'hFF, 1'b1, lat);
    check("lit_m1", 0, dispA, {7'h00, 7'h00, 7'h06});
    check("lit_m1_neg", 0, negA, 1);
    do_load(0, 8'hFF, 1'b0, lat);
    check("lit_ff_u", 0, dispA, {7'h5B, 7'h6D, 7'h6D});
    check("lit_ff_u_neg", 0, negA, 0);

    // Second load while busy is ignored; exactly one done, at the normal time.
    loadA = 1'b1; valA = 8'd42; smA = 1'b0;
    @(negedge CLK); loadA = 1'b0;
    @(negedge CLK);
    @(negedge CLK); loadA = 1'b1; valA = 8'd99;
    @(negedge CLK); loadA = 1'b0;
    ndone = 0; first = -1;
    for (int i = 4; i <= 24; i++) begin
      @(negedge CLK);
      if (doneA) begin ndone++; if (first < 0) first = i; end
    end
    check("busy_load_first", 0, first, LAT);
    check("busy_load_count", 0, ndone, 1);
    check("lit_42", 0, dispA, {7'h00, 7'h66, 7'h5B});

    // Reset in the middle of a conversion aborts it.
    loadA = 1'b1; valA = 8'd42;
    @(negedge CLK); loadA = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (doneA) ndone++;
    end
    check("rst_abort_done", 0, ndone, 0);
    check("rst_abort_disp", 0, dispA, 0);

    // Reset and load together: reset wins.
    RST = 1'b1; loadA = 1'b1; valA = 8'd5;
    @(negedge CLK); RST = 1'b0; loadA = 1'b0;
    check("rst_load_busy", 0, busyA, 0);
    @(negedge CLK);
    check("rst_load_busy2", 0, busyA, 0);

    // Two-digit instance: overflow and the largest fitting value.
    do_load(1, 8'd123, 1'b0, lat);
    check("lit_ovf", 1, ovfB, 1);
    check("lit_ovf_disp", 1, dispB, {7'h40, 7'h40});
    do_load(1, 8'd99, 1'b0, lat);
    check("lit_99_ovf", 1, ovfB, 0);
    check("lit_99", 1, dispB, {7'h6F, 7'h6F});
    do_load(1, 8'h80, 1'b1, lat);
    check("lit_m128_ovf", 1, ovfB, 1);
    check("lit_m128_negB", 1, negB, 1);

    // Randomized traffic on both instances.
    specials = '{8'd0, 8'h80, 8'hFF, 8'h7F, 8'd99, 8'd100, 8'd9, 8'd10};
    for (int c = 0; c < 3000; c++) begin
      loadA = ($urandom_range(0, 3) == 0);
      smA   = $urandom_range(0, 1);
      valA  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      loadB = ($urandom_range(0, 2) == 0);
      smB   = $urandom_range(0, 1);
      valB  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      RST   = ($urandom_range(0, 299) == 0);
      @(negedge CLK);
    end
    loadA = 1'b0; loadB = 1'b0; RST = 1'b0;
    repeat (20) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
